// File: rtl/dma_data_fifo.sv
// dma_data_fifo: synchronous beat FIFO between the DMA read-return side and the write-burst side.
//   Ports:
//     i_clk          clock, all logic on the rising edge
//     i_rst_n        synchronous reset, active-low, highest priority
//     i_flush        synchronous clear of pointers, count and sticky flags (rdata holds)
//     i_wen/i_wdata  push request and data
//     i_ren          pop request; o_rdata is valid the cycle after an accepted pop
//     o_is_empty     count == 0
//     o_is_full      count == DEPTH
//     o_almost_full  count >= AFULL_LEVEL
//     o_count        occupancy 0..DEPTH
//     o_overflow     sticky: push attempted while full
//     o_underflow    sticky: pop attempted while empty
module dma_data_fifo #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_LOG2  = 4,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_wen,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_ren,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_is_empty,
    output logic                  o_is_full,
    output logic                  o_almost_full,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_overflow,
    output logic                  o_underflow
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT  = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] AFULL_CNT = (DEPTH_LOG2+1)'(AFULL_LEVEL);

    // The FIFO must hold at least one complete 8-beat burst.
    if (DEPTH_LOG2 < 3) begin : g_depth_check
        $error("dma_data_fifo: DEPTH must be >= 8");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_empty;
    logic w_full;
    logic w_push_ok;
    logic w_pop_ok;

    // Status comes from the registered count, so a same-cycle pop cannot make room
    // for a push and a same-cycle push cannot feed a pop (no write-through).
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_CNT);
    assign w_push_ok = i_wen & ~w_full;
    assign w_pop_ok  = i_ren & ~w_empty;

    // Storage is deliberately not reset; only accepted pushes outside reset/flush write.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && !i_flush && w_push_ok)
            r_mem[r_wr_ptr] <= i_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rdata     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (i_flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_rdata  <= r_mem[r_rd_ptr];
            end
            if (w_push_ok && !w_pop_ok)
                r_count <= r_count + 1'b1;
            else if (w_pop_ok && !w_push_ok)
                r_count <= r_count - 1'b1;
            if (i_wen && w_full)
                r_overflow <= 1'b1;
            if (i_ren && w_empty)
                r_underflow <= 1'b1;
        end
    end

    assign o_rdata       = r_rdata;
    assign o_is_empty    = w_empty;
    assign o_is_full     = w_full;
    assign o_almost_full = (r_count >= AFULL_CNT);
    assign o_count       = r_count;
    assign o_overflow    = r_overflow;
    assign o_underflow   = r_underflow;
endmodule

// File: tb/tb_dma_data_fifo.sv
// tb_dma_data_fifo: directed and randomized checks of dma_data_fifo against a queue-based model.
module tb_dma_data_fifo;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        wen = 1'b0;
    logic [31:0] wdata = '0;
    logic        ren = 1'b0;
    logic [31:0] rdata;
    logic        is_empty, is_full, almost_full, overflow, underflow;
    logic [4:0]  count;

    int vectors = 0;
    int errors  = 0;
    bit en_chk  = 1'b0;

    logic [31:0] q[$];
    logic [31:0] m_rdata = '0;
    bit          m_ovf = 1'b0;
    bit          m_udf = 1'b0;

    dma_data_fifo dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_wen(wen), .i_wdata(wdata),
        .i_ren(ren), .o_rdata(rdata), .o_is_empty(is_empty), .o_is_full(is_full),
        .o_almost_full(almost_full), .o_count(count), .o_overflow(overflow),
        .o_underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO is a queue; status reflects occupancy before the edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_rdata = '0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (flush) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            automatic int n = q.size();
            if (wen && n == 16) m_ovf = 1'b1;
            if (ren && n == 0) m_udf = 1'b1;
            if (ren && n != 0) m_rdata = q.pop_front();
            if (wen && n != 16) q.push_back(wdata);
        end
    end

    always @(negedge clk) begin
        if (en_chk) begin
            chk("count", 64'(count), 64'(q.size()));
            chk("is_empty", 64'(is_empty), 64'(q.size() == 0));
            chk("is_full", 64'(is_full), 64'(q.size() == 16));
            chk("almost_full", 64'(almost_full), 64'(q.size() >= 12));
            chk("rdata", 64'(rdata), 64'(m_rdata));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            chk("underflow", 64'(underflow), 64'(m_udf));
        end
    end

    task automatic step(input logic r, input logic f, input logic w, input logic [31:0] d,
                        input logic rd);
        rst_n = r; flush = f; wen = w; wdata = d; ren = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held two cycles with a push request pending
        step(1'b0, 1'b0, 1'b1, 32'hDEAD, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'hDEAD, 1'b0);
        en_chk = 1'b1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(is_empty), 64'd1);
        chk("rst_full", 64'(is_full), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_flags", 64'({overflow, underflow}), 64'd0);

        // Burst of 8
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 32'hA0 + 32'(i), 1'b0);
        chk("burst_count", 64'(count), 64'd8);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b0, '0, 1'b1);
            chk("burst_rdata", 64'(rdata), 64'(32'hA0 + 32'(i)));
        end
        chk("burst_empty", 64'(is_empty), 64'd1);

        // Fill to 16, check almost_full threshold, then overflow
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b1, 32'h100 + 32'(i), 1'b0);
            chk("fill_afull", 64'(almost_full), 64'(i + 1 >= 12));
        end
        chk("fill_full", 64'(is_full), 64'd1);
        step(1'b1, 1'b0, 1'b1, 32'hBAD, 1'b0);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_count", 64'(count), 64'd16);
        // wen+ren at full: pop only, first beat returned
        step(1'b1, 1'b0, 1'b1, 32'hBAD, 1'b1);
        chk("full_wr_count", 64'(count), 64'd15);
        chk("full_wr_rdata", 64'(rdata), 64'h100);
        for (int i = 1; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b0, '0, 1'b1);
            chk("drain_rdata", 64'(rdata), 64'(32'h100 + 32'(i)));
        end
        // wen+ren at empty: push only, underflow
        step(1'b1, 1'b0, 1'b1, 32'h77, 1'b1);
        chk("empty_wr_count", 64'(count), 64'd1);
        chk("empty_wr_udf", 64'(underflow), 64'd1);
        chk("empty_wr_rdata", 64'(rdata), 64'h10F);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1);
        chk("empty_wr_pop", 64'(rdata), 64'h77);
        step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        chk("flush_flags", 64'({overflow, underflow}), 64'd0);

        // Steady count of 3 across several pointer wraps
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 32'h200 + 32'(i), 1'b0);
        for (int k = 0; k < 40; k++) begin
            step(1'b1, 1'b0, 1'b1, 32'h203 + 32'(k), 1'b1);
            chk("wrap_rdata", 64'(rdata), 64'(32'h200 + 32'(k)));
            chk("wrap_count", 64'(count), 64'd3);
        end

        // Flush at count 5 with wen/ren also asserted
        step(1'b1, 1'b0, 1'b1, 32'h300, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h301, 1'b0);
        chk("pre_flush_count", 64'(count), 64'd5);
        step(1'b1, 1'b1, 1'b1, 32'h999, 1'b1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_empty", 64'(is_empty), 64'd1);
        chk("flush_rdata", 64'(rdata), 64'h227);
        step(1'b1, 1'b0, 1'b1, 32'h55, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1);
        chk("post_flush_rdata", 64'(rdata), 64'h55);

        // Reset mid-stream
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 32'h400 + 32'(i), 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h1, 1'b1);
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_rdata", 64'(rdata), 64'd0);
        step(1'b1, 1'b0, 1'b1, 32'h66, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1);
        chk("midrst_pop", 64'(rdata), 64'h66);

        // Randomized traffic with phases biased toward filling and draining
        for (int p = 0; p < 12; p++) begin
            automatic int wp = (p % 3 == 0) ? 85 : (p % 3 == 1) ? 20 : 50;
            for (int c = 0; c < 200; c++) begin
                step($urandom_range(0, 399) != 0, $urandom_range(0, 149) == 0,
                     $urandom_range(0, 99) < wp, $urandom, $urandom_range(0, 99) < 100 - wp);
            end
        end

        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
